// File: rtl/control_frame_buffer_write_only.sv
// control_frame_buffer_write_only
// Write-side frame-buffer controller. Pops pixels from the capture FIFO and
// writes them to consecutive addresses starting at the page base. Frames can
// be dropped by an early frame start, or chained back-to-back when the next
// frame start coincides with the last pixel write.
// Optional feature: define DOUBLE_BUFFER_EN to alternate between two pages
// (page 1 based at the latched frame size); otherwise one page based at 0.
module control_frame_buffer_write_only #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [15:0]           resolution_width_i,
    input  logic [15:0]           resolution_depth_i,
    input  logic                  frame_start_i,
    input  logic                  empty_i,
    output logic                  wr_o,
    output logic [ADDR_WIDTH-1:0] addr_wr_o,
    output logic                  page_written_once_o,
    output logic                  frame_done_o,
    output logic                  frame_abort_o,
    output logic                  page_sel_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [31:0]           total_q;      // pixels in the frame being written
    logic [31:0]           pix_cnt;      // pixels written so far in this frame
    logic                  pending;      // frame start seen on the last pixel
    logic [31:0]           start_total;
    logic                  start_ok;
    logic                  last_wr;
    logic                  load;
    logic [ADDR_WIDTH-1:0] start_base;
`ifdef DOUBLE_BUFFER_EN
    logic                  cur_page;     // page the current/next frame goes to
`endif

    // Frame size taken from the live resolution inputs when a frame (re)starts.
    assign start_total = 32'(resolution_width_i) * 32'(resolution_depth_i);
    assign start_ok    = (resolution_width_i != 16'd0) && (resolution_depth_i != 16'd0);

    // The strobe follows FIFO availability with no added latency.
    assign wr_o    = (state == WRITE) && !empty_i;
    assign last_wr = wr_o && (pix_cnt == total_q - 32'd1);

    // Base address of the page a (re)started frame is written to.
    always_comb begin
`ifdef DOUBLE_BUFFER_EN
        start_base = cur_page ? ADDR_WIDTH'(start_total) : '0;
`else
        start_base = '0;
`endif
    end

    // Decide whether this cycle (re)starts a frame and latches a new size.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        load = 1'b0;
        if (start_ok) begin
            case (state)
                IDLE:    load = frame_start_i;
                WRITE:   load = frame_start_i && !last_wr;
                DONE:    load = frame_start_i || pending;
                default: load = 1'b0;
            endcase
        end
    end

    // Frame state machine with registered status pulses and write datapath.
    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: non-blocking assignments let every register see pre-edge values, like real flops.
        if (reset_i) begin
            state               <= IDLE;
            addr_wr_o           <= '0;
            pix_cnt             <= '0;
            total_q             <= '0;
            pending             <= 1'b0;
            frame_done_o        <= 1'b0;
            frame_abort_o       <= 1'b0;
            page_written_once_o <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
            cur_page            <= 1'b0;
            page_sel_o          <= 1'b0;
`endif
        end else begin
            frame_done_o  <= 1'b0;
            frame_abort_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (load) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_wr) begin
                        // A coincident frame start completes this frame and chains the next.
                        state               <= DONE;
                        frame_done_o        <= 1'b1;
                        page_written_once_o <= 1'b1;
                        pending             <= frame_start_i;
`ifdef DOUBLE_BUFFER_EN
                        page_sel_o          <= cur_page;
                        cur_page            <= ~cur_page;
`endif
                    end else if (frame_start_i) begin
                        // Early frame start drops the partial frame on the same page.
                        frame_abort_o <= 1'b1;
                        if (!load) begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    pending <= 1'b0;
                    state   <= load ? WRITE : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Advance on every pixel written; a frame (re)start overrides it.
            if (wr_o) begin
                addr_wr_o <= addr_wr_o + ADDR_WIDTH'(1);
                pix_cnt   <= pix_cnt + 32'd1;
            end
            if (load) begin
                total_q   <= start_total;
                pix_cnt   <= '0;
                addr_wr_o <= start_base;
            end
        end
    end

`ifndef DOUBLE_BUFFER_EN
    assign page_sel_o = 1'b0;
`endif

endmodule

// File: tb/tb_control_frame_buffer_write_only.sv
// Testbench for control_frame_buffer_write_only: a table of per-cycle vectors,
// directed multi-cycle sequences and randomized stimulus, all compared against
// a frame-level reference model (addr = page base + pixels written).
module tb_control_frame_buffer_write_only;

    localparam int AW = 32;
    localparam int OW = AW + 5;
`ifdef DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic [15:0]   width = 16'd0;
    logic [15:0]   depth = 16'd0;
    logic [15:0]   next_width = 16'd0;
    logic [15:0]   next_depth = 16'd0;
    logic          frame_start = 1'b0;
    logic          empty = 1'b1;
    logic          wr;
    logic [AW-1:0] addr;
    logic          once;
    logic          done;
    logic          abort;
    logic          sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (frame level)
    bit     m_busy, m_done, m_abort, m_once, m_sel, m_pend, m_page;
    longint m_total, m_written, m_base;

    typedef struct {
        logic        fs;
        logic        em;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic        exp_done;
        logic        exp_abort;
        logic        exp_once;
    } vec_t;
    vec_t tbl [11];

    control_frame_buffer_write_only #(.ADDR_WIDTH(AW)) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .resolution_width_i  (width),
        .resolution_depth_i  (depth),
        .frame_start_i       (frame_start),
        .empty_i             (empty),
        .wr_o                (wr),
        .addr_wr_o           (addr),
        .page_written_once_o (once),
        .frame_done_o        (done),
        .frame_abort_o       (abort),
        .page_sel_o          (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_abort = 0; m_once = 0; m_sel = 0; m_pend = 0; m_page = 0;
        m_total = 0; m_written = 0; m_base = 0;
    endtask

    task automatic model_start();
        m_total   = longint'(width) * longint'(depth);
        m_base    = (DB && m_page) ? m_total : 0;
        m_written = 0;
        m_busy    = 1;
    endtask

    // Advance the model across one clock edge given this cycle's inputs.
    task automatic model_update(input logic fs, input logic em);
        bit ok, was_done, writing;
        ok       = (width != 0) && (depth != 0);
        was_done = m_done;
        writing  = m_busy && !em;
        m_abort  = 0;
        m_done   = 0;
        if (was_done) begin
            if ((m_pend || fs) && ok) model_start();
            m_pend = 0;
        end else if (m_busy) begin
            if (writing) m_written++;
            if (writing && m_written == m_total) begin
                m_busy = 0; m_done = 1; m_once = 1; m_pend = fs;
                if (DB) begin
                    m_sel  = m_page;
                    m_page = ~m_page;
                end
            end else if (fs) begin
                m_abort = 1;
                if (ok) model_start();
                else    m_busy = 0;
            end
        end else if (fs && ok) begin
            model_start();
        end
    endtask

    // Drive one cycle of inputs, compare all outputs with the model.
    task automatic step(input logic fs, input logic em);
        logic [OW-1:0] act_v, exp_v;
        @(negedge clk);
        frame_start = fs;
        empty       = em;
        width       = next_width;
        depth       = next_depth;
        #1;
        act_v = {wr, addr, done, abort, once, sel};
        exp_v = {m_busy && !em, AW'(m_base + m_written), m_done, m_abort, m_once, m_sel};
        check("model", 64'(act_v), 64'(exp_v));
        model_update(fs, em);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1; frame_start = 1'b0; empty = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] base2;
        base2 = DB ? AW'(40) : '0;

        // 2x2 frame: write, stall, abort after two pixels, full frame, done
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'd4, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0, 1'b1};

        model_reset();
        #1 reset_i = 1'b1;
        #1;
        check("reset_outputs", 64'({wr, addr, done, abort, once, sel}), 64'(0));
        @(negedge clk);
        reset_i = 1'b0;

        // Table-driven vectors
        next_width = 16'd2; next_depth = 16'd2;
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].fs, tbl[i].em);
            check($sformatf("table_%0d", i), 64'({wr, addr, done, abort, once}),
                  64'({tbl[i].exp_wr, tbl[i].exp_addr, tbl[i].exp_done, tbl[i].exp_abort, tbl[i].exp_once}));
        end

        // 10x4 frame, no stalls
        do_reset();
        next_width = 16'd10; next_depth = 16'd4;
        step(1'b1, 1'b0);
        check("idle_no_wr", 64'(wr), 64'(0));
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            check("full_frame_addr", 64'({wr, addr}), {31'd0, 1'b1, 32'(i)});
        end
        step(1'b0, 1'b0);
        check("full_frame_done", 64'({wr, done, once}), 64'(3'b011));
        step(1'b0, 1'b0);
        check("done_one_cycle", 64'({done, once}), 64'(2'b01));

        // FIFO empty for 10 cycles mid-frame
        do_reset();
        step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            check("stall_pre_addr", 64'({wr, addr}), {31'd0, 1'b1, 32'(i)});
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            check("stall_hold", 64'({wr, addr}), {31'd0, 1'b0, 32'd20});
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            check("stall_post_addr", 64'({wr, addr}), {31'd0, 1'b1, 32'(20 + i)});
        end
        step(1'b0, 1'b0);
        check("stall_done", 64'(done), 64'(1));

        // Early frame start after 15 writes aborts and restarts at base
        do_reset();
        step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("abort_cycle", 64'({wr, addr, abort}), {30'd0, 1'b1, 32'd15, 1'b0});
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            if (i == 0) check("abort_pulse", 64'({abort, once, done}), 64'(3'b100));
            check("restart_addr", 64'({wr, addr}), {31'd0, 1'b1, 32'(i)});
        end
        step(1'b0, 1'b0);
        check("restart_done", 64'({done, abort}), 64'(2'b10));

        // Frame start coincident with the 40th write chains the next frame
        do_reset();
        step(1'b1, 1'b0);
        for (int i = 0; i < 39; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("last_write", 64'({wr, addr}), {31'd0, 1'b1, 32'd39});
        step(1'b0, 1'b0);
        check("chain_done", 64'({done, abort, sel}), 64'(3'b100));
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            check("page2_addr", 64'({wr, addr}), {31'd0, 1'b1, base2 + 32'(i)});
        end
        step(1'b0, 1'b0);
        check("page2_done_sel", 64'({done, sel}), 64'({1'b1, DB}));

        // Asynchronous reset mid-frame
        step(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_reset", 64'({wr, addr, done, abort, once, sel}), 64'(0));
        model_reset();
        @(negedge clk);
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check("post_reset_idle", 64'({wr, addr, done, abort}), 64'(0));
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("post_reset_start", 64'({wr, addr}), {31'd0, 1'b1, 32'd0});

        // Randomized stimulus against the model
        do_reset();
        next_width = 16'd3; next_depth = 16'd2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                next_width = 16'($urandom_range(0, 5));
                next_depth = 16'($urandom_range(0, 5));
            end
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_frame_buffer_write_only.md
CONTROL_FRAME_BUFFER_WRITE_ONLY -- requirements
Module: control_frame_buffer_write_only

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of the frame-buffer write address.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port resolution_width_i, input, 16, pixels per line.
REQ-005 SHALL have port resolution_depth_i, input, 16, lines per frame.
REQ-006 SHALL have port frame_start_i, input, 1, one-cycle pulse from capture marking the start of a camera frame.
REQ-007 SHALL have port empty_i, input, 1, high when the capture pixel FIFO holds no data.
REQ-008 SHALL have port wr_o, output, 1, write strobe that also pops the capture FIFO.
REQ-009 SHALL have port addr_wr_o, output, ADDR_WIDTH, pixel address for the current write.
REQ-010 SHALL have port page_written_once_o, output, 1, sticky flag: at least one full frame is stored; enables the read-side controller.
REQ-011 SHALL have port frame_done_o, output, 1, one-cycle pulse after the last pixel of a frame is written.
REQ-012 SHALL have port frame_abort_o, output, 1, one-cycle pulse when a frame is dropped by an early frame_start_i.
REQ-013 SHALL have port page_sel_o, output, 1, page most recently completed (feature of REQ-030).

Function
REQ-014 SHALL implement the states IDLE, WRITE and DONE.
REQ-015 IDLE SHALL move to WRITE on frame_start_i=1 only when both latched resolution fields are nonzero; otherwise it SHALL stay in IDLE.
REQ-016 On entry to WRITE, the block SHALL latch width and depth, compute total = width*depth as 32 bits unsigned, clear the pixel counter and load addr_wr_o with the page base.
REQ-017 wr_o SHALL be combinational, equal to (state==WRITE) and not empty_i; there is no extra latency between FIFO data being available and the write strobe.
REQ-018 addr_wr_o SHALL be registered; it SHALL increment by 1 in each cycle in which wr_o=1, and SHALL hold otherwise.
REQ-019 When wr_o=1 and the pixel counter equals total-1, the block SHALL go to DONE on the next edge.
REQ-020 DONE SHALL last exactly one cycle; during it frame_done_o=1, page_written_once_o is set, and the state returns to IDLE.
REQ-021 frame_start_i during WRITE, before the last pixel is written, SHALL pulse frame_abort_o, restart the same page at its base address, and re-latch the resolution.
REQ-022 frame_start_i in the same cycle as the last pixel write SHALL complete that frame normally (REQ-019/020) without an abort.
REQ-023 The frame_start_i pulse in REQ-022 SHALL be held as pending, so that DONE goes directly to WRITE on the next page instead of to IDLE.
REQ-024 Resolution input changes during WRITE SHALL be ignored until the next frame start.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH with no error indication.

Reset
REQ-026 On reset_i=1, the block SHALL immediately, without waiting for a clock edge, set state=IDLE, addr_wr_o=0, pixel counter=0, the pending flag=0 and page_sel_o=0.
REQ-027 On reset_i=1, wr_o SHALL be 0 and frame_done_o, frame_abort_o and page_written_once_o SHALL all be 0.
REQ-028 A reset asserted during WRITE SHALL discard the partial frame; no output pulse is generated for it.
REQ-029 page_written_once_o SHALL be cleared only by reset.

Configuration
REQ-030 With DOUBLE_BUFFER_EN defined, the write page SHALL alternate between 0 and 1 on each completed frame (not on aborted ones).
REQ-031 With DOUBLE_BUFFER_EN defined, the page base SHALL be 0 for page 0 and the latched total for page 1.
REQ-032 With DOUBLE_BUFFER_EN defined, page_sel_o SHALL update in the DONE cycle to the page just completed.
REQ-033 Without DOUBLE_BUFFER_EN, the page base SHALL always be 0 and page_sel_o SHALL be tied to 0.

Verification
REQ-034 Bench SHALL cover: width=10, depth=4, empty_i=0, one frame_start_i -> 40 consecutive wr_o cycles with addr 0..39, then frame_done_o for 1 cycle and page_written_once_o=1.
REQ-035 Bench SHALL cover: empty_i=1 for 10 cycles mid-frame -> wr_o=0 and addr_wr_o held for exactly those 10 cycles; the frame then completes at addr 39.
REQ-036 Bench SHALL cover: frame_start_i after 15 writes -> frame_abort_o pulses, addr_wr_o returns to the page base, and page_written_once_o stays 0.
REQ-037 Bench SHALL cover, with DOUBLE_BUFFER_EN: two frames -> the second frame is written at addr 40..79, and page_sel_o reads 0 after the first frame and 1 after the second.
REQ-038 Bench SHALL cover: frame_start_i coincident with write 40 -> frame_done_o pulses with no abort, and the next frame starts at the next page base.
REQ-039 Bench SHALL cover: reset_i asserted mid-frame, asynchronous to clk_i -> all outputs go to 0 immediately, and the block waits in IDLE for frame_start_i.
